// File: rtl/collision_engine.sv
// Per-frame collision and scoring engine for air hockey: drives ball direction bits,
// keeps both scores and sequences goal-hold, serve and game-over.
module collision_engine #(
  parameter int COORD_W     = 11,
  parameter int SCREEN_W    = 320,
  parameter int SCREEN_H    = 240,
  parameter int BALL_SIZE   = 4,
  parameter int PADDLE_W    = 4,
  parameter int PADDLE_H    = 40,
  parameter int GOAL_TOP    = 80,
  parameter int GOAL_BOT    = 160,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [COORD_W-1:0] x_ball,
  input  logic [COORD_W-1:0] y_ball,
  input  logic [COORD_W-1:0] x_paddle1,
  input  logic [COORD_W-1:0] y_paddle1,
  input  logic [COORD_W-1:0] x_paddle2,
  input  logic [COORD_W-1:0] y_paddle2,
  output logic               horizontal,
  output logic               vertical,
  output logic               stop,
  output logic               serve,
  output logic               goal_p1,
  output logic               goal_p2,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               game_over
);

  localparam int CW1    = COORD_W + 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [CW1-1:0]     L_ZERO   = CW1'(0);
  localparam logic [CW1-1:0]     L_BALL   = CW1'(BALL_SIZE);
  localparam logic [CW1-1:0]     L_PAD_W  = CW1'(PADDLE_W);
  localparam logic [CW1-1:0]     L_PAD_H  = CW1'(PADDLE_H);
  localparam logic [CW1-1:0]     L_SCR_W  = CW1'(SCREEN_W);
  localparam logic [CW1-1:0]     L_SCR_H  = CW1'(SCREEN_H);
  localparam logic [CW1-1:0]     L_GTOP   = CW1'(GOAL_TOP);
  localparam logic [CW1-1:0]     L_GBOT   = CW1'(GOAL_BOT);
  localparam logic [SCORE_W-1:0] L_WIN    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] L_SMAX   = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] L_SONE   = SCORE_W'(1);
  localparam logic [HOLD_W-1:0]  L_HLAST  = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  L_HONE   = HOLD_W'(1);

  typedef enum logic [1:0] {
    S_PLAY  = 2'd0,
    S_HOLD  = 2'd1,
    S_SERVE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t              r_state;
  logic [HOLD_W-1:0]   r_hold;
  logic                r_last_p2;
  logic                r_horizontal;
  logic                r_vertical;
  logic                r_stop;
  logic                r_serve;
  logic                r_goal_p1;
  logic                r_goal_p2;
  logic [SCORE_W-1:0]  r_score1;
  logic [SCORE_W-1:0]  r_score2;
  logic                r_game_over;

  // Sums are one bit wider than the coordinates so they never wrap.
  logic [CW1-1:0] w_xb, w_yb, w_xb_r, w_yb_b;
  logic [CW1-1:0] w_x1, w_y1, w_x1_r, w_y1_b;
  logic [CW1-1:0] w_x2, w_y2, w_x2_r, w_y2_b;
  logic           w_in_goal, w_at_left, w_at_right, w_at_top, w_at_bot;
  logic           w_left_goal, w_right_goal, w_hit_p1, w_hit_p2, w_win;
  logic [SCORE_W-1:0] w_score1_inc, w_score2_inc;

  assign w_xb   = {1'b0, x_ball};
  assign w_yb   = {1'b0, y_ball};
  assign w_x1   = {1'b0, x_paddle1};
  assign w_y1   = {1'b0, y_paddle1};
  assign w_x2   = {1'b0, x_paddle2};
  assign w_y2   = {1'b0, y_paddle2};
  assign w_xb_r = w_xb + L_BALL;
  assign w_yb_b = w_yb + L_BALL;
  assign w_x1_r = w_x1 + L_PAD_W;
  assign w_y1_b = w_y1 + L_PAD_H;
  assign w_x2_r = w_x2 + L_PAD_W;
  assign w_y2_b = w_y2 + L_PAD_H;

  assign w_in_goal    = (w_yb >= L_GTOP) && (w_yb <= L_GBOT);
  assign w_at_left    = (w_xb <= L_ZERO);
  assign w_at_right   = (w_xb_r >= L_SCR_W);
  assign w_at_top     = (w_yb <= L_ZERO);
  assign w_at_bot     = (w_yb_b >= L_SCR_H);
  assign w_left_goal  = w_at_left && w_in_goal;
  assign w_right_goal = w_at_right && w_in_goal;

  assign w_hit_p1 = (w_xb <= w_x1_r) && (w_xb_r >= w_x1) && (w_yb <= w_y1_b) && (w_yb_b >= w_y1);
  assign w_hit_p2 = (w_xb <= w_x2_r) && (w_xb_r >= w_x2) && (w_yb <= w_y2_b) && (w_yb_b >= w_y2);

  assign w_score1_inc = (r_score1 == L_SMAX) ? r_score1 : r_score1 + L_SONE;
  assign w_score2_inc = (r_score2 == L_SMAX) ? r_score2 : r_score2 + L_SONE;
  assign w_win        = (r_score1 >= L_WIN) || (r_score2 >= L_WIN);

  // Game FSM with all outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_PLAY;
      r_hold       <= '0;
      r_last_p2    <= 1'b0;
      r_horizontal <= 1'b0;
      r_vertical   <= 1'b1;
      r_stop       <= 1'b0;
      r_serve      <= 1'b0;
      r_goal_p1    <= 1'b0;
      r_goal_p2    <= 1'b0;
      r_score1     <= '0;
      r_score2     <= '0;
      r_game_over  <= 1'b0;
    end else begin
      r_serve   <= 1'b0;
      r_goal_p1 <= 1'b0;
      r_goal_p2 <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (enable) begin
            if (w_left_goal) begin
              r_score2  <= w_score2_inc;
              r_goal_p2 <= 1'b1;
              r_stop    <= 1'b1;
              r_hold    <= '0;
              r_last_p2 <= 1'b1;
              r_state   <= S_HOLD;
            end else if (w_right_goal) begin
              r_score1  <= w_score1_inc;
              r_goal_p1 <= 1'b1;
              r_stop    <= 1'b1;
              r_hold    <= '0;
              r_last_p2 <= 1'b0;
              r_state   <= S_HOLD;
            end else begin
              // Direction guard stops a paddle re-flipping the ball while the boxes still overlap.
              if (w_hit_p1 && !r_horizontal) begin
                r_horizontal <= 1'b1;
              end else if (w_hit_p2 && r_horizontal) begin
                r_horizontal <= 1'b0;
              end else if (w_at_left) begin
                r_horizontal <= 1'b1;
              end else if (w_at_right) begin
                r_horizontal <= 1'b0;
              end else begin
                r_horizontal <= r_horizontal;
              end
              if (w_at_top) begin
                r_vertical <= 1'b0;
              end else if (w_at_bot) begin
                r_vertical <= 1'b1;
              end else begin
                r_vertical <= r_vertical;
              end
            end
          end else begin
            r_state <= S_PLAY;
          end
        end
        S_HOLD: begin
          r_stop <= 1'b1;
          if (enable) begin
            if (r_hold == L_HLAST) begin
              r_hold <= '0;
              if (w_win) begin
                r_state     <= S_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_state <= S_SERVE;
              end
            end else begin
              r_hold <= r_hold + L_HONE;
            end
          end else begin
            r_hold <= r_hold;
          end
        end
        S_SERVE: begin
          r_serve      <= 1'b1;
          r_stop       <= 1'b0;
          r_vertical   <= 1'b1;
          r_horizontal <= r_last_p2;
          r_state      <= S_PLAY;
        end
        S_OVER: begin
          r_stop      <= 1'b1;
          r_game_over <= 1'b1;
        end
        default: begin
          r_state <= S_PLAY;
        end
      endcase
    end
  end

  assign horizontal = r_horizontal;
  assign vertical   = r_vertical;
  assign stop       = r_stop;
  assign serve      = r_serve;
  assign goal_p1    = r_goal_p1;
  assign goal_p2    = r_goal_p2;
  assign score1     = r_score1;
  assign score2     = r_score2;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_collision_engine.sv
// Directed bench for collision_engine: a frame-level game model is checked every cycle,
// plus literal expectations at the points of interest.
module tb_collision_engine;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [10:0] x_ball = 11'd0, y_ball = 11'd0;
  logic [10:0] x_paddle1 = 11'd10, y_paddle1 = 11'd180;
  logic [10:0] x_paddle2 = 11'd306, y_paddle2 = 11'd180;
  logic        horizontal, vertical, stop, serve, goal_p1, goal_p2, game_over;
  logic [3:0]  score1, score2;

  int n_cmp = 0;
  int n_bad = 0;

  collision_engine dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .x_ball(x_ball), .y_ball(y_ball),
    .x_paddle1(x_paddle1), .y_paddle1(y_paddle1),
    .x_paddle2(x_paddle2), .y_paddle2(y_paddle2),
    .horizontal(horizontal), .vertical(vertical), .stop(stop), .serve(serve),
    .goal_p1(goal_p1), .goal_p2(goal_p2), .score1(score1), .score2(score2),
    .game_over(game_over)
  );

  always #5 clock = ~clock;

  // Game model: frozen frames left, pending serve, finished flag, and direction/score state.
  int m_h = 0, m_v = 1, m_stop = 0, m_serve = 0, m_g1 = 0, m_g2 = 0;
  int m_s1 = 0, m_s2 = 0, m_over = 0, m_frozen_left = 0, m_serve_due = 0, m_last = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_h = 0; m_v = 1; m_stop = 0; m_serve = 0; m_g1 = 0; m_g2 = 0;
      m_s1 = 0; m_s2 = 0; m_over = 0; m_frozen_left = 0; m_serve_due = 0; m_last = 0;
    end else begin
      int xb, yb, x1, y1, x2, y2, in_goal, p1, p2;
      xb = x_ball; yb = y_ball; x1 = x_paddle1; y1 = y_paddle1; x2 = x_paddle2; y2 = y_paddle2;
      m_serve = 0; m_g1 = 0; m_g2 = 0;
      if (m_over != 0) begin
        m_stop = 1;
      end else if (m_serve_due != 0) begin
        m_serve_due = 0; m_serve = 1; m_stop = 0; m_v = 1;
        m_h = (m_last == 2) ? 1 : 0;
      end else if (enable) begin
        if (m_frozen_left > 0) begin
          m_frozen_left--;
          if (m_frozen_left == 0) begin
            if (m_s1 >= 7 || m_s2 >= 7) m_over = 1;
            else m_serve_due = 1;
          end
        end else begin
          in_goal = (yb >= 80 && yb <= 160);
          p1 = (xb <= x1 + 4) && (xb + 4 >= x1) && (yb <= y1 + 40) && (yb + 4 >= y1);
          p2 = (xb <= x2 + 4) && (xb + 4 >= x2) && (yb <= y2 + 40) && (yb + 4 >= y2);
          if (xb <= 0 && in_goal) begin
            if (m_s2 < 15) m_s2++;
            m_g2 = 1; m_stop = 1; m_frozen_left = 60; m_last = 2;
          end else if (xb + 4 >= 320 && in_goal) begin
            if (m_s1 < 15) m_s1++;
            m_g1 = 1; m_stop = 1; m_frozen_left = 60; m_last = 1;
          end else begin
            if (p1 && m_h == 0) m_h = 1;
            else if (p2 && m_h == 1) m_h = 0;
            else if (xb <= 0) m_h = 1;
            else if (xb + 4 >= 320) m_h = 0;
            if (yb <= 0) m_v = 0;
            else if (yb + 4 >= 240) m_v = 1;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      cmp("horizontal", int'(horizontal), m_h);
      cmp("vertical",   int'(vertical),   m_v);
      cmp("stop",       int'(stop),       m_stop | m_over);
      cmp("serve",      int'(serve),      m_serve);
      cmp("goal_p1",    int'(goal_p1),    m_g1);
      cmp("goal_p2",    int'(goal_p2),    m_g2);
      cmp("score1",     int'(score1),     m_s1);
      cmp("score2",     int'(score2),     m_s2);
      cmp("game_over",  int'(game_over),  m_over);
    end
  end

  task automatic tick(input logic en, input int xb, input int yb);
    enable = en;
    x_ball = xb[10:0];
    y_ball = yb[10:0];
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic goal_cycle(input int xb);
    tick(1'b1, xb, 120);
    repeat (60) tick(1'b1, 160, 20);
    tick(1'b0, 160, 20);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    cmp("rst_h", int'(horizontal), 0);
    cmp("rst_v", int'(vertical), 1);
    cmp("rst_stop", int'(stop), 0);
    cmp("rst_scores", int'(score1) + int'(score2), 0);
    cmp("rst_over", int'(game_over), 0);
    @(negedge clock);

    // Left wall outside the goal window, then walk to the right wall.
    tick(1'b1, 0, 20);
    cmp("left_wall_h", int'(horizontal), 1);
    for (int x = 100; x <= 292; x += 24) tick(1'b1, x, 20);
    cmp("pre_right_h", int'(horizontal), 1);
    tick(1'b1, 316, 20);
    cmp("right_wall_h", int'(horizontal), 0);
    cmp("right_wall_v", int'(vertical), 1);

    // Paddle 1 bounce and direction guard, then paddle 2 bounce.
    x_paddle1 = 11'd10; y_paddle1 = 11'd100;
    x_paddle2 = 11'd300; y_paddle2 = 11'd100;
    tick(1'b1, 13, 120);
    cmp("paddle1_h", int'(horizontal), 1);
    repeat (3) tick(1'b1, 13, 120);
    cmp("paddle1_guard_h", int'(horizontal), 1);
    tick(1'b1, 297, 120);
    cmp("paddle2_h", int'(horizontal), 0);

    // Disabled ticks hold everything.
    repeat (3) tick(1'b0, 0, 120);
    cmp("idle_score2", int'(score2), 0);

    // Left goal, hold, serve.
    tick(1'b1, 0, 120);
    cmp("goal_p2_pulse", int'(goal_p2), 1);
    cmp("goal_score2", int'(score2), 1);
    cmp("goal_stop", int'(stop), 1);
    tick(1'b1, 0, 120);
    cmp("goal_p2_clear", int'(goal_p2), 0);
    repeat (59) tick(1'b1, 160, 20);
    cmp("hold_stop", int'(stop), 1);
    tick(1'b0, 160, 20);
    cmp("serve_pulse", int'(serve), 1);
    cmp("serve_stop", int'(stop), 0);
    cmp("serve_h", int'(horizontal), 1);
    tick(1'b0, 160, 20);
    cmp("serve_clear", int'(serve), 0);

    // Corner and bottom wall.
    tick(1'b1, 316, 20);
    cmp("pre_corner_h", int'(horizontal), 0);
    tick(1'b1, 0, 0);
    cmp("corner_h", int'(horizontal), 1);
    cmp("corner_v", int'(vertical), 0);
    tick(1'b1, 100, 236);
    cmp("bottom_v", int'(vertical), 1);

    // Right goal: serve heads toward player 1's side of play (-x).
    goal_cycle(316);
    cmp("p1_score", int'(score1), 1);
    cmp("p1_serve_h", int'(horizontal), 0);

    // Six more left goals reach the winning score.
    repeat (6) goal_cycle(0);
    cmp("over_flag", int'(game_over), 1);
    cmp("over_stop", int'(stop), 1);
    cmp("over_score2", int'(score2), 7);
    tick(1'b1, 0, 120);
    cmp("over_frozen", int'(score2), 7);
    cmp("over_no_pulse", int'(goal_p2), 0);

    // Fresh game, then asynchronous reset in the middle of a hold.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    tick(1'b1, 0, 120);
    repeat (10) tick(1'b1, 160, 20);
    #1 reset_n = 1'b0;
    #1;
    cmp("async_stop", int'(stop), 0);
    cmp("async_score2", int'(score2), 0);
    cmp("async_h", int'(horizontal), 0);
    cmp("async_v", int'(vertical), 1);
    @(negedge clock);
    reset_n = 1'b1;
    tick(1'b1, 0, 20);
    cmp("after_reset_h", int'(horizontal), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
- Parametrised per-frame collision and scoring engine for the air-hockey datapath.
- Once per frame tick (enable), checks the ball box against the screen walls, both paddles and both goal mouths.
- Drives direction bits to the ball mover, keeps both scores, and sequences goal-hold / serve / game-over.
- Sits between the position registers and the ball/paddle movers; direction outputs keep the encoding the ball mover already uses.

Parameters:
- COORD_W, 11, width of all coordinate inputs.
- SCREEN_W, 320, playfield width in pixels.
- SCREEN_H, 240, playfield height in pixels.
- BALL_SIZE, 4, ball box side in pixels.
- PADDLE_W, 4, paddle box width.
- PADDLE_H, 40, paddle box height.
- GOAL_TOP, 80, first y row of each goal mouth (inclusive).
- GOAL_BOT, 160, last y row of each goal mouth (inclusive).
- SCORE_W, 4, score counter width.
- WIN_SCORE, 7, score that ends the game.
- HOLD_FRAMES, 60, enable ticks the ball is frozen after a goal.

Ports:
- clock, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- enable, in, 1, frame tick; evaluation occurs only on cycles where it is 1.
- x_ball, in, COORD_W, ball top-left x.
- y_ball, in, COORD_W, ball top-left y.
- x_paddle1, in, COORD_W, left paddle top-left x.
- y_paddle1, in, COORD_W, left paddle top-left y.
- x_paddle2, in, COORD_W, right paddle top-left x.
- y_paddle2, in, COORD_W, right paddle top-left y.
- horizontal, out, 1, 1 = ball moves +x, 0 = ball moves -x.
- vertical, out, 1, 1 = ball moves -y, 0 = ball moves +y.
- stop, out, 1, freeze ball motion.
- serve, out, 1, one-cycle pulse: ball mover reloads centre position.
- goal_p1, out, 1, one-cycle pulse: player 1 (left) scored.
- goal_p2, out, 1, one-cycle pulse: player 2 (right) scored.
- score1, out, SCORE_W, player 1 score.
- score2, out, SCORE_W, player 2 score.
- game_over, out, 1, a score reached WIN_SCORE.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - horizontal=0, vertical=1, stop=0, serve=0, goal_p1=0, goal_p2=0.
  - score1=0, score2=0, game_over=0, hold counter=0, state=PLAY.
  - Reset mid-HOLD or in OVER returns to PLAY with all of the above values.
- Arithmetic: all sums (x+BALL_SIZE, x+PADDLE_W, y+PADDLE_H) are computed at COORD_W+1 bits, so there is no wrap. Use only >= / <= comparisons, never ==.
- enable=0: all registers hold; pulses are 0.
- State PLAY (on enable), checks in priority order:
  1. Left goal: x_ball<=0 and GOAL_TOP<=y_ball<=GOAL_BOT → score2+1, goal_p2 pulse, stop=1, counter=0 → HOLD; last_scorer=2.
  2. Right goal: x_ball+BALL_SIZE>=SCREEN_W and y_ball within the goal window → score1+1, goal_p1 pulse, stop=1 → HOLD; last_scorer=1.
  3. Paddle 1: ball box overlaps the paddle box (inclusive edges) and horizontal=0 → horizontal<=1. Paddle 2: overlaps and horizontal=1 → horizontal<=0. The direction guard prevents re-flipping while the boxes still overlap. The vertical bit is unchanged by paddle hits.
  4. Side walls (outside the goal window only): x_ball<=0 → horizontal<=1; x_ball+BALL_SIZE>=SCREEN_W → horizontal<=0.
  5. Top/bottom walls, evaluated independently of steps 3–4 unless a goal fired: y_ball<=0 → vertical<=0; y_ball+BALL_SIZE>=SCREEN_H → vertical<=1.
  - A corner hit updates both bits in the same tick.
- State HOLD:
  - stop=1; the counter increments per enable.
  - When counter==HOLD_FRAMES-1 on an enable:
    - If score1 or score2 >= WIN_SCORE → OVER.
    - Else → SERVE.
- State SERVE (one cycle, no enable needed):
  - serve=1, stop<=0, vertical<=1.
  - horizontal<=1 if last_scorer=2, else 0, so the ball moves away from the conceding player's goal toward the scorer.
  - Then → PLAY.
- State OVER: stop=1, game_over=1, scores frozen. Exit only by reset.
- Scores saturate at 2^SCORE_W-1.
- goal_p*/serve are exactly one clock wide.

Test Plan:
- Reset, ball (100,100), horizontal=1, enable ticks with x stepping to 316 at y=20 → horizontal falls to 0 on the tick x+4>=320; vertical unchanged.
- Paddle1 at (10,100), ball at (13,120) with horizontal=0, enable → horizontal=1. Hold the same overlap for 3 more ticks → horizontal stays 1.
- Ball at (0,120), enable → goal_p2 one cycle, score2=1, stop=1. After 60 enables: serve pulse, stop=0, horizontal=1.
- Ball at (0,0), enable → horizontal=1 and vertical=0 on the same tick (corner, outside goal window).
- Drive 7 left-goal events → after the 7th hold completes, game_over=1, stop=1, score2=7. Further goals do not change the scores.
- Assert reset_n=0 asynchronously mid-HOLD (no clock edge) → stop=0, scores=0, horizontal=0, vertical=1 immediately.
